// File: rtl/dsp_frame_sequencer.sv
// rtl/dsp_frame_sequencer.sv - time-multiplexes one multi-channel frame through a shared DSP core
module dsp_frame_sequencer #(
  parameter int data_width     = 16,
  parameter int n_channels     = 2,
  parameter int timeout_cycles = 4096,
  parameter int ctr_width      = 32,
  localparam int ch_width      = (n_channels > 1) ? $clog2(n_channels) : 1,
  localparam int tmr_width     = $clog2(timeout_cycles)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             enable,
  input  logic                             bypass,
  input  logic [n_channels*data_width-1:0] in_frame,
  input  logic                             in_valid,
  output logic                             ready,
  output logic [n_channels*data_width-1:0] out_frame,
  output logic                             out_valid,
  output logic                             core_tick,
  output logic [ch_width-1:0]              core_channel,
  output logic [data_width-1:0]            core_sample_in,
  input  logic                             core_ready,
  input  logic [data_width-1:0]            core_sample_out,
  output logic                             overrun,
  output logic [ctr_width-1:0]             overrun_count,
  output logic [ctr_width-1:0]             frame_count,
  output logic                             error
);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE, S_ERROR} state_t;

  state_t                           state_q, state_d;
  logic [ch_width-1:0]              ch_q, ch_next;
  logic [tmr_width-1:0]             timer_q;
  logic [n_channels*data_width-1:0] latched_q, result_q, result_merged;
  logic                             accept, capture, last_ch, timed_out, busy;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    ready         = (state_q == S_IDLE);
    core_tick     = (state_q == S_ISSUE);
    busy          = (state_q == S_ISSUE) || (state_q == S_WAIT) || (state_q == S_DONE);
    accept        = (state_q == S_IDLE) && in_valid && enable && !bypass;
    // the first WAIT cycle (timer 0) may still see ready from the previous channel
    capture       = (state_q == S_WAIT) && (timer_q != '0) && core_ready;
    last_ch       = (ch_q == ch_width'(n_channels - 1));
    timed_out     = (state_q == S_WAIT) && !capture && (timer_q == tmr_width'(timeout_cycles - 1));
    ch_next       = ch_q + 1'b1;
    result_merged = result_q;
    result_merged[ch_q*data_width +: data_width] = core_sample_out;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (capture)        state_d = last_ch ? S_DONE : S_ISSUE;
        else if (timed_out) state_d = S_ERROR;
      end
      S_DONE:  state_d = S_IDLE;
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_frame      <= '0;
      out_valid      <= 1'b0;
      core_channel   <= '0;
      core_sample_in <= '0;
      overrun        <= 1'b0;
      overrun_count  <= '0;
      frame_count    <= '0;
      error          <= 1'b0;
      ch_q           <= '0;
      timer_q        <= '0;
      latched_q      <= '0;
      result_q       <= '0;
    end else begin
      out_valid <= 1'b0;
      overrun   <= 1'b0;
      if (busy && in_valid) begin
        overrun <= 1'b1;
        if (overrun_count != '1) overrun_count <= overrun_count + 1'b1;
      end
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            if (!enable) begin
              out_frame   <= '0;
              out_valid   <= 1'b1;
              frame_count <= frame_count + 1'b1;
            end else if (bypass) begin
              out_frame   <= in_frame;
              out_valid   <= 1'b1;
              frame_count <= frame_count + 1'b1;
            end else begin
              latched_q      <= in_frame;
              ch_q           <= '0;
              core_channel   <= '0;
              core_sample_in <= in_frame[data_width-1:0];
            end
          end
        end
        S_ISSUE: timer_q <= '0;
        S_WAIT: begin
          timer_q <= timer_q + 1'b1;
          if (capture) begin
            result_q <= result_merged;
            if (last_ch) begin
              // publishing at the capture edge lines out_frame up with the DONE-cycle pulse
              out_frame   <= result_merged;
              out_valid   <= 1'b1;
              frame_count <= frame_count + 1'b1;
            end else begin
              ch_q           <= ch_next;
              core_channel   <= ch_next;
              core_sample_in <= latched_q[ch_next*data_width +: data_width];
            end
          end else if (timed_out) begin
            error <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/dsp_frame_sequencer.md
Name: dsp_frame_sequencer

Overview:
Multi-channel successor to the single-sample pipeline front-end. It accepts one frame of n_channels samples per in_valid strobe and time-multiplexes the channels through the shared DSP core with a tick/ready handshake. It collects the per-channel results into an output frame and adds bypass, mute, overrun counting and a core-watchdog error state. It sits between the I2S/codec frame interface and dsp_core.

Parameters:
data_width, 16, sample width in bits (signed two's complement)
n_channels, 2, channels per frame (>=1)
timeout_cycles, 4096, max WAIT cycles per channel before error (>=2)
ctr_width, 32, width of frame and overrun counters

Ports:
clk  input  1  system clock
reset  input  1  synchronous active-high reset
enable  input  1  0 = mute: frames pass as zeros, core not ticked
bypass  input  1  1 = frames pass through unchanged, core not ticked (enable=0 has priority)
in_frame  input  n_channels*data_width  channel k at bits [k*data_width +: data_width]
in_valid  input  1  one-cycle frame strobe
ready  output  1  high only in IDLE
out_frame  output  n_channels*data_width  last completed frame, same packing
out_valid  output  1  one-cycle pulse when out_frame updates
core_tick  output  1  one-cycle start pulse to core
core_channel  output  max(1,$clog2(n_channels))  channel index for current tick
core_sample_in  output  data_width  sample for current tick
core_ready  input  1  core idle/result valid (level)
core_sample_out  input  data_width  core result
overrun  output  1  one-cycle pulse on dropped frame
overrun_count  output  ctr_width  saturating dropped-frame count
frame_count  output  ctr_width  wrapping count of emitted frames
error  output  1  sticky watchdog error

Behaviour:
- Reset: state IDLE; ready=1; out_frame=0; out_valid=0; core_tick=0; core_channel=0; core_sample_in=0; overrun=0; both counters=0; error=0. Reset mid-frame abandons the frame with no out_valid.
- States: IDLE, ISSUE, WAIT, DONE, ERROR.
- IDLE, in_valid=1:
  - enable=0: out_frame<=0, out_valid=1 next cycle, frame_count++, stay IDLE.
  - else bypass=1: out_frame<=in_frame, same 1-cycle latency.
  - else: latch in_frame, ch<=0, go to ISSUE, ready<=0.
- ISSUE (1 cycle): core_tick=1, core_channel=ch, core_sample_in=latched[ch]; go to WAIT, timer<=0.
- WAIT:
  - The first WAIT cycle ignores core_ready (guard for stale ready).
  - After that, core_ready=1 captures core_sample_out into result[ch]. If ch==n_channels-1, go to DONE; else ch++ and go to ISSUE.
  - timer increments each WAIT cycle. On timer==timeout_cycles-1 without capture: go to ERROR, error<=1.
- DONE (1 cycle): out_frame<=result, out_valid=1, frame_count++ (wraps), then IDLE, ready=1.
- Latency with core_ready already high: in_valid sampled at edge t gives out_valid high in cycle t+3*n_channels+1 (n_channels=2: 7 cycles).
- Overrun: in_valid in ISSUE/WAIT/DONE drops the frame. overrun pulses 1 cycle; overrun_count saturates at all-ones. The current frame is unaffected.
- ERROR: sticky until reset. ready=0, core_tick=0, out_frame holds, in_valid ignored (not counted as overrun).
- enable/bypass are sampled only at frame acceptance; changes mid-frame take effect on the next frame.
- core_tick is never asserted outside ISSUE. core_channel/core_sample_in hold their values through WAIT.

Test Plan:
- Reset, n_channels=2; core model answers 3 cycles after tick; in_frame={ch1=0x0002,ch0=0x0001}, core returns x*2 -> out_frame={0x0004,0x0002}, single out_valid, frame_count=1, two core_tick pulses with core_channel 0 then 1.
- Core_ready held high constantly; in_valid at cycle 10 -> out_valid exactly in cycle 17; ready low in cycles 11-17.
- bypass=1, in_frame=0x8000_7FFF -> out_frame=0x8000_7FFF next cycle, no core_tick. enable=0 with bypass=1 -> out_frame=0, no core_tick.
- Second in_valid 2 cycles after the first -> overrun pulse, overrun_count=1, first frame completes correctly. Preload overrun_count to all-ones -> it stays all-ones.
- timeout_cycles=8, core_ready held low -> error=1 after 8 WAIT cycles, ready=0, no out_valid; further in_valid ignored; reset clears error and ready=1.
- Assert reset during WAIT of channel 1 -> all outputs at reset values next cycle, no out_valid; next frame processes normally.
